// File: rtl/dispatch_pkg.sv
// Shared types for the loop dispatch front end: instruction classes, FSM states and
// the loop-event flag pair sent on the APU channel.
package dispatch_pkg;

    typedef enum logic [1:0] {
        TYPE_MEM  = 2'b00,
        TYPE_PROC = 2'b01,
        TYPE_LOOP = 2'b10,
        TYPE_CTRL = 2'b11
    } instr_type_e;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StError
    } state_e;

    // The sub-op selector is the top payload bit, just below the 2-bit type field.
    localparam int unsigned SubopOffset = 3;

    function automatic int unsigned subop_index(input int unsigned isa_width);
        return isa_width - SubopOffset;
    endfunction

    // Upper bits of apu_data; the loop level is appended below these.
    typedef struct packed {
        logic is_end;
        logic is_last;
    } apu_event_t;

endpackage

// File: rtl/loop_dispatch_unit_if.sv
// Output channels of the dispatch unit: memory queue, processing queue and loop events.
interface loop_dispatch_unit_if #(
    parameter int unsigned ISA_WIDTH  = 18,
    parameter int unsigned LOOP_DEPTH = 4
);
    localparam int unsigned PayloadWidth = ISA_WIDTH - 2;
    localparam int unsigned ApuWidth     = 2 + $clog2(LOOP_DEPTH);

    logic                    mem_valid;
    logic                    mem_ready;
    logic [PayloadWidth-1:0] mem_data;
    logic                    proc_valid;
    logic                    proc_ready;
    logic [PayloadWidth-1:0] proc_data;
    logic                    apu_valid;
    logic                    apu_ready;
    logic [ApuWidth-1:0]     apu_data;

    modport master (
        output mem_valid, mem_data, proc_valid, proc_data, apu_valid, apu_data,
        input  mem_ready, proc_ready, apu_ready
    );

    modport slave (
        input  mem_valid, mem_data, proc_valid, proc_data, apu_valid, apu_data,
        output mem_ready, proc_ready, apu_ready
    );

endinterface

// File: rtl/loop_stack.sv
// Hardware loop stack: each entry holds the body start address and the iterations left.
module loop_stack #(
    parameter int unsigned ADDR_WIDTH  = 18,
    parameter int unsigned COUNT_WIDTH = 12,
    parameter int unsigned LOOP_DEPTH  = 4,
    localparam int unsigned LevelWidth = $clog2(LOOP_DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   dec,
    input  logic [ADDR_WIDTH-1:0]  push_addr,
    input  logic [COUNT_WIDTH-1:0] push_count,
    output logic [ADDR_WIDTH-1:0]  top_addr,
    output logic [COUNT_WIDTH-1:0] top_remaining,
    output logic                   empty,
    output logic                   full,
    output logic [LevelWidth-1:0]  level
);

    logic [LevelWidth:0]    used_q;
    logic [ADDR_WIDTH-1:0]  addr_q [LOOP_DEPTH];
    logic [COUNT_WIDTH-1:0] rem_q  [LOOP_DEPTH];
    logic [LevelWidth-1:0]  top_idx;
    logic [LevelWidth-1:0]  push_idx;

    assign top_idx  = LevelWidth'(used_q - 1'b1);
    assign push_idx = used_q[LevelWidth-1:0];

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            used_q <= '0;
            for (int i = 0; i < LOOP_DEPTH; i++) begin
                addr_q[i] <= '0;
                rem_q[i]  <= '0;
            end
        end else if (push) begin
            addr_q[push_idx] <= push_addr;
            rem_q[push_idx]  <= push_count;
            used_q           <= used_q + 1'b1;
        end else if (pop) begin
            used_q <= used_q - 1'b1;
        end else if (dec) begin
            rem_q[top_idx] <= rem_q[top_idx] - 1'b1;
        end
    end

    assign top_addr      = addr_q[top_idx];
    assign top_remaining = rem_q[top_idx];
    assign empty         = (used_q == '0);
    assign full          = (used_q == (LevelWidth + 1)'(LOOP_DEPTH));
    assign level         = top_idx;

endmodule

// File: rtl/loop_dispatch_unit.sv
// Instruction front end: fetches one instruction per cycle, dispatches memory/processing
// payloads to their queues and runs nested hardware loops off the loop stack.
module loop_dispatch_unit
    import dispatch_pkg::*;
#(
    parameter int unsigned ISA_WIDTH   = 18,
    parameter int unsigned ADDR_WIDTH  = 18,
    parameter int unsigned LOOP_DEPTH  = 4,
    parameter int unsigned COUNT_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] kernel_start_instruction,
    output logic [ADDR_WIDTH-1:0] pc,
    input  logic [ISA_WIDTH-1:0]  raw_instruction,
    input  logic                  instr_valid,
    loop_dispatch_unit_if.master  chan,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam int unsigned PayloadWidth = ISA_WIDTH - 2;
    localparam int unsigned LevelWidth   = $clog2(LOOP_DEPTH);
    localparam int unsigned SubopIdx     = subop_index(ISA_WIDTH);

    state_e                  state_q;
    logic [ADDR_WIDTH-1:0]   pc_q, pc_inc, pc_next;
    logic                    busy_q, done_q, error_q;

    instr_type_e             itype;
    logic [PayloadWidth-1:0] payload;
    logic                    subop;
    logic [COUNT_WIDTH-1:0]  count;

    logic                    mem_free, proc_free, apu_free, target_free;
    logic                    accept, fault, halt;
    logic                    load_mem, load_proc, load_apu;
    apu_event_t              apu_evt;
    logic [LevelWidth-1:0]   apu_level;

    logic                    st_clear, st_push, st_pop, st_dec;
    logic [ADDR_WIDTH-1:0]   st_top_addr;
    logic [COUNT_WIDTH-1:0]  st_top_rem;
    logic                    st_empty, st_full;
    logic [LevelWidth-1:0]   st_level;

    assign itype   = instr_type_e'(raw_instruction[ISA_WIDTH-1 -: 2]);
    assign payload = raw_instruction[PayloadWidth-1:0];
    assign subop   = raw_instruction[SubopIdx];
    assign count   = payload[COUNT_WIDTH-1:0];

    loop_stack #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .COUNT_WIDTH (COUNT_WIDTH),
        .LOOP_DEPTH  (LOOP_DEPTH)
    ) u_loop_stack (
        .clk           (clk),
        .reset         (reset),
        .clear         (st_clear),
        .push          (st_push),
        .pop           (st_pop),
        .dec           (st_dec),
        .push_addr     (pc_inc),
        .push_count    (count),
        .top_addr      (st_top_addr),
        .top_remaining (st_top_rem),
        .empty         (st_empty),
        .full          (st_full),
        .level         (st_level)
    );

    always_comb begin
        mem_free  = !chan.mem_valid || chan.mem_ready;
        proc_free = !chan.proc_valid || chan.proc_ready;
        apu_free  = !chan.apu_valid || chan.apu_ready;
        unique case (itype)
            TYPE_MEM:  target_free = mem_free;
            TYPE_PROC: target_free = proc_free;
            TYPE_LOOP: target_free = apu_free;
            TYPE_CTRL: target_free = 1'b1;
        endcase

        accept    = (state_q == StRun) && instr_valid && target_free;
        pc_inc    = pc_q + 1'b1;
        pc_next   = pc_inc;
        fault     = 1'b0;
        halt      = 1'b0;
        load_mem  = 1'b0;
        load_proc = 1'b0;
        load_apu  = 1'b0;
        st_push   = 1'b0;
        st_pop    = 1'b0;
        st_dec    = 1'b0;
        apu_evt   = '0;
        apu_level = st_level;
        st_clear  = (state_q == StIdle) && start;

        if (accept) begin
            unique case (itype)
                TYPE_MEM:  load_mem  = 1'b1;
                TYPE_PROC: load_proc = 1'b1;
                TYPE_LOOP: begin
                    if (!subop) begin
                        if (count == '0 || st_full) begin
                            fault = 1'b1;
                        end else begin
                            st_push         = 1'b1;
                            load_apu        = 1'b1;
                            apu_evt.is_last = (count == COUNT_WIDTH'(1));
                            apu_level       = st_empty ? '0 : st_level + 1'b1;
                        end
                    end else if (st_empty) begin
                        fault = 1'b1;
                    end else begin
                        load_apu       = 1'b1;
                        apu_evt.is_end = 1'b1;
                        // Back-edge jumps on the accepting edge, so loops cost no bubble.
                        if (st_top_rem > COUNT_WIDTH'(1)) begin
                            st_dec  = 1'b1;
                            pc_next = st_top_addr;
                        end else begin
                            st_pop          = 1'b1;
                            apu_evt.is_last = 1'b1;
                        end
                    end
                end
                TYPE_CTRL: begin
                    if (subop) begin
                        if (!st_empty) fault = 1'b1;
                        else           halt  = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            pc_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q <= StRun;
                        pc_q    <= kernel_start_instruction;
                        busy_q  <= 1'b1;
                    end
                end
                StRun: begin
                    if (fault) begin
                        state_q <= StError;
                        busy_q  <= 1'b0;
                        error_q <= 1'b1;
                    end else if (accept) begin
                        pc_q <= pc_next;
                        if (halt) begin
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                StError: state_q <= StError;
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            chan.mem_valid <= 1'b0;
            chan.mem_data  <= '0;
        end else if (load_mem) begin
            chan.mem_valid <= 1'b1;
            chan.mem_data  <= payload;
        end else if (chan.mem_ready) begin
            chan.mem_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            chan.proc_valid <= 1'b0;
            chan.proc_data  <= '0;
        end else if (load_proc) begin
            chan.proc_valid <= 1'b1;
            chan.proc_data  <= payload;
        end else if (chan.proc_ready) begin
            chan.proc_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            chan.apu_valid <= 1'b0;
            chan.apu_data  <= '0;
        end else if (load_apu) begin
            chan.apu_valid <= 1'b1;
            chan.apu_data  <= {apu_evt, apu_level};
        end else if (chan.apu_ready) begin
            chan.apu_valid <= 1'b0;
        end
    end

    assign pc    = pc_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign error = error_q;

endmodule

// File: tb/tb_loop_dispatch_unit.sv
// Scoreboard bench for loop_dispatch_unit: expected channel payloads are queued per
// program and retired by a handshake monitor.
module tb_loop_dispatch_unit;

    localparam int unsigned IW = 18;
    localparam int unsigned AW = 18;
    localparam int unsigned LD = 4;
    localparam int unsigned CW = 12;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] kstart;
    logic [AW-1:0] pc;
    logic [IW-1:0] raw;
    logic          instr_valid;
    logic          busy, done, error;

    logic [IW-1:0] rom [256];
    logic [15:0]   exp_mem[$];
    logic [15:0]   exp_proc[$];
    logic [3:0]    exp_apu[$];
    logic [15:0]   mon_exp16;
    logic [3:0]    mon_exp4;
    int            tests_run = 0;
    int            tests_failed = 0;

    loop_dispatch_unit_if #(.ISA_WIDTH(IW), .LOOP_DEPTH(LD)) bus ();

    loop_dispatch_unit #(
        .ISA_WIDTH   (IW),
        .ADDR_WIDTH  (AW),
        .LOOP_DEPTH  (LD),
        .COUNT_WIDTH (CW)
    ) dut (
        .clk                      (clk),
        .reset                    (reset),
        .start                    (start),
        .kernel_start_instruction (kstart),
        .pc                       (pc),
        .raw_instruction          (raw),
        .instr_valid              (instr_valid),
        .chan                     (bus),
        .busy                     (busy),
        .done                     (done),
        .error                    (error)
    );

    always #5 clk = ~clk;

    always_comb raw = rom[pc[7:0]];

    function automatic logic [IW-1:0] i_mem(input logic [15:0] p);
        return {2'b00, p};
    endfunction
    function automatic logic [IW-1:0] i_proc(input logic [15:0] p);
        return {2'b01, p};
    endfunction
    function automatic logic [IW-1:0] i_ls(input logic [CW-1:0] c);
        return {2'b10, 1'b0, 3'b000, c};
    endfunction
    function automatic logic [IW-1:0] i_le();
        return {2'b10, 1'b1, 15'h0};
    endfunction
    function automatic logic [IW-1:0] i_halt();
        return {2'b11, 1'b1, 15'h0};
    endfunction

    // Retire one expected item per observed handshake; in-flight data under reset is dropped.
    always @(negedge clk) begin
        if (!reset && bus.mem_valid && bus.mem_ready) begin
            tests_run++;
            if (exp_mem.size() == 0) begin
                tests_failed++;
                $display("FAIL mem_unexpected: got %h, required no transfer", bus.mem_data);
            end else begin
                mon_exp16 = exp_mem.pop_front();
                if (bus.mem_data !== mon_exp16) begin
                    tests_failed++;
                    $display("FAIL mem_data: got %h, required %h", bus.mem_data, mon_exp16);
                end
            end
        end
        if (!reset && bus.proc_valid && bus.proc_ready) begin
            tests_run++;
            if (exp_proc.size() == 0) begin
                tests_failed++;
                $display("FAIL proc_unexpected: got %h, required no transfer", bus.proc_data);
            end else begin
                mon_exp16 = exp_proc.pop_front();
                if (bus.proc_data !== mon_exp16) begin
                    tests_failed++;
                    $display("FAIL proc_data: got %h, required %h", bus.proc_data, mon_exp16);
                end
            end
        end
        if (!reset && bus.apu_valid && bus.apu_ready) begin
            tests_run++;
            if (exp_apu.size() == 0) begin
                tests_failed++;
                $display("FAIL apu_unexpected: got %b, required no transfer", bus.apu_data);
            end else begin
                mon_exp4 = exp_apu.pop_front();
                if (bus.apu_data !== mon_exp4) begin
                    tests_failed++;
                    $display("FAIL apu_data: got %b, required %b", bus.apu_data, mon_exp4);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 18'h30000;
    endtask

    task automatic launch(input logic [AW-1:0] base);
        kstart = base;
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    task automatic run_until(input int budget, output int cycles);
        cycles = -1;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (done || error) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; kstart = '0; instr_valid = 1'b1;
        bus.mem_ready = 1'b1; bus.proc_ready = 1'b1; bus.apu_ready = 1'b1;
        clear_rom();
        tick();
        tick();
        reset = 1'b0;
        tests_run++;
        if (pc !== '0) begin
            tests_failed++;
            $display("FAIL reset_pc: got %h, required 0", pc);
        end
        tests_run++;
        if ({busy, done, error, bus.mem_valid, bus.proc_valid, bus.apu_valid} !== 6'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: got %b, required 000000",
                     {busy, done, error, bus.mem_valid, bus.proc_valid, bus.apu_valid});
        end
        tests_run++;
        if ({bus.mem_data, bus.proc_data, bus.apu_data} !== 36'h0) begin
            tests_failed++;
            $display("FAIL reset_data: got %h, required 0",
                     {bus.mem_data, bus.proc_data, bus.apu_data});
        end
    endtask

    task automatic test_straight_line(input string name);
        int cyc;
        rom[8'h10] = i_mem(16'h1234);
        rom[8'h11] = i_proc(16'h5678);
        rom[8'h12] = i_mem(16'h9abc);
        rom[8'h13] = i_halt();
        exp_mem.push_back(16'h1234);
        exp_mem.push_back(16'h9abc);
        exp_proc.push_back(16'h5678);
        launch(18'h10);
        run_until(50, cyc);
        tests_run++;
        if (cyc !== 4 || done !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s_cycles: got %0d (done=%b), required 4 (done=1)", name, cyc, done);
        end
        tests_run++;
        if (pc !== 18'h14 || busy !== 1'b0 || error !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s_end_state: got pc=%h busy=%b error=%b, required pc=14 busy=0 error=0",
                     name, pc, busy, error);
        end
        tick();
        tests_run++;
        if (done !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s_done_pulse: got %b, required 0", name, done);
        end
        tick();
        tick();
        tests_run++;
        if (exp_mem.size() + exp_proc.size() + exp_apu.size() != 0) begin
            tests_failed++;
            $display("FAIL %s_drain: got %0d pending, required 0", name,
                     exp_mem.size() + exp_proc.size() + exp_apu.size());
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        rom[8'h20] = i_mem(16'haaaa);
        rom[8'h21] = i_mem(16'hbbbb);
        rom[8'h22] = i_halt();
        exp_mem.push_back(16'haaaa);
        exp_mem.push_back(16'hbbbb);
        bus.mem_ready = 1'b0;
        launch(18'h20);
        tick();
        tests_run++;
        if (bus.mem_valid !== 1'b1 || bus.mem_data !== 16'haaaa || pc !== 18'h21) begin
            tests_failed++;
            $display("FAIL bp_first: got v=%b d=%h pc=%h, required v=1 d=aaaa pc=21",
                     bus.mem_valid, bus.mem_data, pc);
        end
        for (int k = 0; k < 5; k++) begin
            tick();
            tests_run++;
            if (bus.mem_valid !== 1'b1 || bus.mem_data !== 16'haaaa || pc !== 18'h21) begin
                tests_failed++;
                $display("FAIL bp_stall%0d: got v=%b d=%h pc=%h, required v=1 d=aaaa pc=21",
                         k, bus.mem_valid, bus.mem_data, pc);
            end
        end
        bus.mem_ready = 1'b1;
        tick();
        tests_run++;
        if (bus.mem_valid !== 1'b1 || bus.mem_data !== 16'hbbbb || pc !== 18'h22) begin
            tests_failed++;
            $display("FAIL bp_release: got v=%b d=%h pc=%h, required v=1 d=bbbb pc=22",
                     bus.mem_valid, bus.mem_data, pc);
        end
        run_until(20, cyc);
        tests_run++;
        if (cyc !== 1 || pc !== 18'h23) begin
            tests_failed++;
            $display("FAIL bp_halt: got cycles=%0d pc=%h, required 1 pc=23", cyc, pc);
        end
        tick();
        tick();
        tests_run++;
        if (exp_mem.size() != 0) begin
            tests_failed++;
            $display("FAIL bp_drain: got %0d pending, required 0", exp_mem.size());
        end
    endtask

    task automatic test_single_loop();
        int cyc;
        rom[8'h30] = i_ls(12'd3);
        rom[8'h31] = i_proc(16'h0f00);
        rom[8'h32] = i_le();
        rom[8'h33] = i_halt();
        repeat (3) exp_proc.push_back(16'h0f00);
        exp_apu.push_back(4'b0000);
        exp_apu.push_back(4'b1000);
        exp_apu.push_back(4'b1000);
        exp_apu.push_back(4'b1100);
        launch(18'h30);
        run_until(60, cyc);
        tests_run++;
        if (cyc !== 8 || done !== 1'b1 || pc !== 18'h34) begin
            tests_failed++;
            $display("FAIL loop1_end: got cycles=%0d done=%b pc=%h, required 8 1 34", cyc, done, pc);
        end
        tick();
        tick();
        tests_run++;
        if (exp_proc.size() + exp_apu.size() != 0) begin
            tests_failed++;
            $display("FAIL loop1_drain: got %0d pending, required 0",
                     exp_proc.size() + exp_apu.size());
        end
    endtask

    task automatic test_nested_loop();
        int cyc;
        logic [3:0] ev [9] = '{4'b0000, 4'b0001, 4'b1001, 4'b1101, 4'b1000,
                               4'b0001, 4'b1001, 4'b1101, 4'b1100};
        rom[8'h40] = i_ls(12'd2);
        rom[8'h41] = i_ls(12'd2);
        rom[8'h42] = i_mem(16'h00aa);
        rom[8'h43] = i_le();
        rom[8'h44] = i_le();
        rom[8'h45] = i_halt();
        repeat (4) exp_mem.push_back(16'h00aa);
        foreach (ev[i]) exp_apu.push_back(ev[i]);
        launch(18'h40);
        run_until(80, cyc);
        tests_run++;
        if (cyc !== 14 || done !== 1'b1 || pc !== 18'h46) begin
            tests_failed++;
            $display("FAIL nest_end: got cycles=%0d done=%b pc=%h, required 14 1 46", cyc, done, pc);
        end
        tick();
        tick();
        tests_run++;
        if (exp_mem.size() + exp_apu.size() != 0) begin
            tests_failed++;
            $display("FAIL nest_drain: got %0d pending, required 0",
                     exp_mem.size() + exp_apu.size());
        end
    endtask

    task automatic test_error_case(input string name, input logic [AW-1:0] base);
        int cyc;
        logic [AW-1:0] pc_hold;
        launch(base);
        run_until(40, cyc);
        tests_run++;
        if (cyc < 0 || error !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s_flags: got cycles=%0d error=%b busy=%b done=%b, required error=1 busy=0 done=0",
                     name, cyc, error, busy, done);
        end
        tick();
        for (int k = 0; k < 4; k++) begin
            tick();
            tests_run++;
            if ({bus.mem_valid, bus.proc_valid, bus.apu_valid} !== 3'b000) begin
                tests_failed++;
                $display("FAIL %s_quiet%0d: got valids=%b, required 000", name, k,
                         {bus.mem_valid, bus.proc_valid, bus.apu_valid});
            end
        end
        pc_hold = pc;
        launch(18'h10);
        tick();
        tests_run++;
        if (busy !== 1'b0 || error !== 1'b1 || pc !== pc_hold) begin
            tests_failed++;
            $display("FAIL %s_start_ignored: got busy=%b error=%b pc=%h, required 0 1 %h",
                     name, busy, error, pc, pc_hold);
        end
        tests_run++;
        if (exp_mem.size() + exp_proc.size() + exp_apu.size() != 0) begin
            tests_failed++;
            $display("FAIL %s_drain: got %0d pending, required 0", name,
                     exp_mem.size() + exp_proc.size() + exp_apu.size());
        end
        do_reset();
    endtask

    task automatic test_errors();
        rom[8'h50] = i_mem(16'h0055);
        rom[8'h51] = i_ls(12'd0);
        rom[8'h52] = i_mem(16'h0066);
        exp_mem.push_back(16'h0055);
        test_error_case("err_count0", 18'h50);

        rom[8'h60] = i_le();
        rom[8'h61] = i_mem(16'h0077);
        test_error_case("err_empty_end", 18'h60);

        for (int i = 0; i <= LD; i++) rom[8'h70 + i] = i_ls(12'd2);
        rom[8'h70 + LD + 1] = i_mem(16'h0088);
        for (int i = 0; i < LD; i++) exp_apu.push_back(4'(i));
        test_error_case("err_overflow", 18'h70);

        rom[8'h80] = i_ls(12'd2);
        rom[8'h81] = i_halt();
        exp_apu.push_back(4'b0000);
        test_error_case("err_halt_nested", 18'h80);
    endtask

    task automatic test_reset_mid_loop();
        exp_apu.push_back(4'b0000);
        exp_apu.push_back(4'b1000);
        exp_proc.push_back(16'h0f00);
        launch(18'h30);
        repeat (4) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tests_run++;
        if ({pc, busy, done, error, bus.mem_valid, bus.proc_valid, bus.apu_valid} !== '0) begin
            tests_failed++;
            $display("FAIL midreset_state: got pc=%h flags=%b, required all 0", pc,
                     {busy, done, error, bus.mem_valid, bus.proc_valid, bus.apu_valid});
        end
        tests_run++;
        if ({bus.mem_data, bus.proc_data, bus.apu_data} !== 36'h0) begin
            tests_failed++;
            $display("FAIL midreset_data: got %h, required 0",
                     {bus.mem_data, bus.proc_data, bus.apu_data});
        end
        tests_run++;
        if (exp_proc.size() + exp_apu.size() != 0) begin
            tests_failed++;
            $display("FAIL midreset_retired: got %0d pending, required 0",
                     exp_proc.size() + exp_apu.size());
        end
        test_straight_line("rerun");
    endtask

    initial begin
        test_reset();
        test_straight_line("straight");
        test_backpressure();
        test_single_loop();
        test_nested_loop();
        test_errors();
        test_reset_mid_loop();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
